fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/fetch_next_pc.sv | 46 ++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions: fetch FSM state encoding, reset PC
//                default, opcode constants and immediate sign-extend helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Default word address the fetch unit starts from after reset.
    localparam logic [15:0] c_RESET_PC_DEFAULT = 16'h0000;

    // Fetch unit state encoding (explicit 2-bit width).
    localparam int          c_STATE_W  = 2;
    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_FETCH = 2'd1;
    localparam logic [1:0]  c_ST_ISSUE = 2'd2;
    localparam logic [1:0]  c_ST_HALT  = 2'd3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_FETCH = c_ST_FETCH,
        ST_ISSUE = c_ST_ISSUE,
        ST_HALT  = c_ST_HALT
    } fetch_state_t;

    // Opcode field occupies instr[15:11].
    localparam logic [4:0] c_OP_BRN  = 5'h10;
    localparam logic [4:0] c_OP_BAL  = 5'h11;
    localparam logic [4:0] c_OP_JAL  = 5'h12;
    localparam logic [4:0] c_OP_JMP  = 5'h13;
    localparam logic [4:0] c_OP_JALR = 5'h14;
    localparam logic [4:0] c_OP_JR   = 5'h15;
    localparam logic [4:0] c_OP_HLT  = 5'h1F;

    // Sign-extend the 11-bit jump displacement to a full PC-width offset.
    function automatic logic [15:0] sext11(input logic [10:0] imm);
        return {{5{imm[10]}}, imm};
    endfunction

    // Sign-extend the 8-bit branch displacement to a full PC-width offset.
    function automatic logic [15:0] sext8(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_next_pc
//  Description : Combinational next-PC selection and link address. Register
//                redirects beat the PC-relative jump, which beats a taken
//                branch, which beats sequential flow. All arithmetic wraps
//                modulo 2^16.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc
    import cpu_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [15:0] instr,
    input  logic        pc_src,
    input  logic        jmp,
    input  logic        jalr,
    input  logic        jr,
    input  logic [15:0] reg_target,
    output logic [15:0] next_pc,
    output logic [15:0] link_pc
);

    logic [15:0] w_pc_inc;
    logic        w_unused_opcode;

    // Opcode bits are decoded elsewhere; only the displacement field matters here.
    assign w_unused_opcode = ^instr[15:11];

    assign w_pc_inc = pc + 16'd1;
    assign link_pc  = w_pc_inc;

    // Prioritised redirect selection; displacements are relative to PC+1.
    always_comb begin
        next_pc = w_pc_inc;
        if (jr || jalr) begin
            next_pc = reg_target;
        end else if (jmp) begin
            next_pc = w_pc_inc + sext11(instr[10:0]);
        end else if (pc_src) begin
            next_pc = w_pc_inc + sext8(instr[7:0]);
        end
    end

endmodule : fetch_next_pc
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch unit. Requests one word at PC, holds it in
//                an instruction register until the core consumes it, then
//                advances PC (sequential, branch, jump or register-indirect)
//                and fetches again. A halting instruction parks the unit in
//                HALT until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = c_RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic [15:0]        instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pc_src,
    input  logic               jmp,
    input  logic               jalr,
    input  logic               jr,
    input  logic               hlt,
    input  logic [15:0]        reg_target,
    output logic [15:0]        link_pc,
    output logic               halted,
    output logic [15:0]        retired
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [15:0]  r_pc;
    logic [15:0]  r_instr;
    logic [15:0]  r_retired;
    logic [15:0]  w_next_pc;
    logic         w_fetch_done;
    logic         w_consume;

    // Next PC and link address are pure functions of PC, instruction and redirects.
    fetch_next_pc u_next_pc (
        .pc         (r_pc),
        .instr      (r_instr),
        .pc_src     (pc_src),
        .jmp        (jmp),
        .jalr       (jalr),
        .jr         (jr),
        .reg_target (reg_target),
        .next_pc    (w_next_pc),
        .link_pc    (link_pc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; ack and start are only honoured in their own states,
    // and redirects only matter on the consume handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_fetch_done = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = hlt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Instruction register captures read data on the accepting ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= 16'h0000;
        end else if (w_fetch_done) begin
            r_instr <= imem_rdata;
        end
    end

    // PC and retired counter advance together when the core consumes instr;
    // a halting instruction still updates PC and is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_retired <= 16'h0000;
        end else if (w_consume) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + 16'd1;
        end
    end

    // Memory address is PC truncated or zero-extended to the memory width.
    generate
        if (IMEM_AW == 16) begin : g_addr_exact
            assign imem_addr = r_pc;
        end else if (IMEM_AW > 16) begin : g_addr_wide
            assign imem_addr = {{(IMEM_AW-16){1'b0}}, r_pc};
        end else begin : g_addr_narrow
            assign imem_addr = r_pc[IMEM_AW-1:0];
        end
    endgenerate

    assign imem_req    = (r_state == ST_FETCH);
    assign instr_valid = (r_state == ST_ISSUE);
    assign halted      = (r_state == ST_HALT);
    assign instr       = r_instr;
    assign retired     = r_retired;

endmodule : fetch_unit
`default_nettype wire
